discharge_feedback_monitor: RTL

Downstream consumer of the discharge controller on the clk_100M domain. It watches the per-pulse gate activity and the breakdown flag. It classifies every discharge attempt as normal, short or open, and averages the sampled gap voltage over a fixed window. Once per window it publishes a packed 32-bit feedback word, which replaces the constant currently tied to the SPI slave's feedback_data_async / change_feedback_ack inputs.

---
 rtl/discharge_feedback_monitor_pkg.sv | 32 +++
 rtl/discharge_feedback_monitor_if.sv | 20 ++
 rtl/discharge_feedback_monitor_pulse_classifier.sv | 93 +++++++++
 rtl/discharge_feedback_monitor.sv | 89 ++++++++
 4 files changed

// File: rtl/discharge_feedback_monitor_pkg.sv
// Shared types for the discharge feedback monitor: pulse FSM states, event codes
// and the field layout of the packed feedback word (also used by the SPI command decoder).
package discharge_feedback_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_BD = 2'd1,
    ST_BURNING = 2'd2
  } pulse_state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_NORMAL = 2'd1,
    EV_SHORT  = 2'd2,
    EV_OPEN   = 2'd3
  } pulse_event_t;

  localparam int FB_FIELD_W    = 8;
  localparam int FB_NORMAL_LSB = 24;
  localparam int FB_SHORT_LSB  = 16;
  localparam int FB_OPEN_LSB   = 8;
  localparam int FB_VOL_LSB    = 0;

  // Counter slot i counts CNT_EVENT[i] and lands at FB_CNT_LSB[i] in the word.
  localparam pulse_event_t CNT_EVENT [3] = '{EV_NORMAL, EV_SHORT, EV_OPEN};
  localparam int FB_CNT_LSB [3] = '{FB_NORMAL_LSB, FB_SHORT_LSB, FB_OPEN_LSB};

  function automatic logic [7:0] sat_inc8(input logic [7:0] value, input logic inc);
    return (inc && value != 8'hFF) ? value + 8'd1 : value;
  endfunction

endpackage

// File: rtl/discharge_feedback_monitor_if.sv
// Controller-facing inputs and SPI-facing feedback outputs of the monitor.
interface discharge_feedback_monitor_if;
  logic        is_operation;
  logic        pulse_on;
  logic        is_breakdown;
  logic [15:0] sample_voltage;
  logic [31:0] feedback_data;
  logic        feedback_update;
  logic [15:0] last_bd_delay;

  modport master (
    output is_operation, pulse_on, is_breakdown, sample_voltage,
    input  feedback_data, feedback_update, last_bd_delay
  );

  modport slave (
    input  is_operation, pulse_on, is_breakdown, sample_voltage,
    output feedback_data, feedback_update, last_bd_delay
  );
endinterface

// File: rtl/discharge_feedback_monitor_pulse_classifier.sv
// Tracks one discharge attempt at a time and emits a single-cycle NORMAL/SHORT/OPEN
// event in the cycle pulse_on falls; delay counts cycles from the pulse_on rise.
module discharge_feedback_monitor_pulse_classifier
  import discharge_feedback_monitor_pkg::*;
#(
  parameter logic [15:0] SHORT_DELAY_MAX = 16'd300
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         is_operation,
  input  logic         pulse_on,
  input  logic         is_breakdown,
  output pulse_event_t pulse_event,
  output logic [15:0]  last_bd_delay
);

  pulse_state_t state_reg, state_next;
  logic         pulse_on_reg;
  logic [15:0]  delay_reg, delay_next;
  logic [15:0]  bd_delay_reg, bd_delay_next;
  logic [15:0]  delay_inc;
  logic         rise;
  logic         fall;

  assign rise      = pulse_on & ~pulse_on_reg;
  assign fall      = ~pulse_on & pulse_on_reg;
  assign delay_inc = (delay_reg == 16'hFFFF) ? delay_reg : delay_reg + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      pulse_on_reg <= 1'b0;
      delay_reg    <= 16'd0;
      bd_delay_reg <= 16'd0;
    end else begin
      state_reg    <= state_next;
      pulse_on_reg <= pulse_on;
      delay_reg    <= delay_next;
      bd_delay_reg <= bd_delay_next;
    end
  end

  // delay_reg freezes once breakdown is seen, so BURNING classifies on it directly.
  always_comb begin
    state_next    = state_reg;
    delay_next    = delay_reg;
    bd_delay_next = bd_delay_reg;
    pulse_event   = EV_NONE;
    if (!is_operation) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rise) begin
            delay_next = 16'd0;
            if (is_breakdown) begin
              bd_delay_next = 16'd0;
              state_next    = ST_BURNING;
            end else begin
              state_next = ST_WAIT_BD;
            end
          end
        end
        ST_WAIT_BD: begin
          delay_next = delay_inc;
          if (is_breakdown) begin
            bd_delay_next = delay_inc;
            if (fall) begin
              // Breakdown seen on the very cycle the gate drops still counts as a burn.
              state_next  = ST_IDLE;
              pulse_event = (delay_inc < SHORT_DELAY_MAX) ? EV_SHORT : EV_NORMAL;
            end else begin
              state_next = ST_BURNING;
            end
          end else if (fall) begin
            state_next  = ST_IDLE;
            pulse_event = EV_OPEN;
          end
        end
        ST_BURNING: begin
          if (fall) begin
            state_next  = ST_IDLE;
            pulse_event = (delay_reg < SHORT_DELAY_MAX) ? EV_SHORT : EV_NORMAL;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign last_bd_delay = bd_delay_reg;

endmodule

// File: rtl/discharge_feedback_monitor.sv
// Per-window statistics of discharge attempts plus average gap voltage, published
// as one packed 32-bit feedback word with a single-cycle update strobe.
module discharge_feedback_monitor
  import discharge_feedback_monitor_pkg::*;
#(
  parameter int          WINDOW_LOG2     = 20,
  parameter logic [15:0] SHORT_DELAY_MAX = 16'd300,
  parameter int          VOL_SHIFT       = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  discharge_feedback_monitor_if.slave    bus
);

  localparam int ACC_W = 16 + WINDOW_LOG2;

  pulse_event_t            pulse_event;
  logic [15:0]             last_bd_delay;
  logic [WINDOW_LOG2-1:0]  win_cnt_reg;
  logic [ACC_W-1:0]        acc_reg;
  logic [ACC_W-1:0]        acc_sum;
  logic [ACC_W-1:0]        avg_full;
  logic [7:0]              avg_vol;
  logic [7:0]              cnt_reg  [3];
  logic [7:0]              cnt_next [3];
  logic [31:0]             fb_word;
  logic [31:0]             feedback_data_reg;
  logic                    feedback_update_reg;
  logic                    window_end;

  discharge_feedback_monitor_pulse_classifier #(
    .SHORT_DELAY_MAX (SHORT_DELAY_MAX)
  ) u_pulse_classifier (
    .clk           (clk),
    .rst           (rst),
    .is_operation  (bus.is_operation),
    .pulse_on      (bus.pulse_on),
    .is_breakdown  (bus.is_breakdown),
    .pulse_event   (pulse_event),
    .last_bd_delay (last_bd_delay)
  );

  // Window-end word includes this cycle's event and sample, hence the *_next values.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_evt_cnt
    assign cnt_next[gi] = sat_inc8(cnt_reg[gi], pulse_event == CNT_EVENT[gi]);
    assign fb_word[FB_CNT_LSB[gi] +: FB_FIELD_W] = cnt_next[gi];
  end

  assign acc_sum    = acc_reg + {{WINDOW_LOG2{1'b0}}, bus.sample_voltage};
  assign avg_full   = acc_sum >> (WINDOW_LOG2 + VOL_SHIFT);
  assign avg_vol    = (|avg_full[ACC_W-1:8]) ? 8'hFF : avg_full[7:0];
  assign fb_word[FB_VOL_LSB +: FB_FIELD_W] = avg_vol;
  assign window_end = &win_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_reg         <= '0;
      acc_reg             <= '0;
      cnt_reg             <= '{default: '0};
      feedback_data_reg   <= 32'd0;
      feedback_update_reg <= 1'b0;
    end else begin
      feedback_update_reg <= 1'b0;
      if (!bus.is_operation) begin
        // Machine stopped: drop the partial window, keep the last published word.
        win_cnt_reg <= '0;
        acc_reg     <= '0;
        cnt_reg     <= '{default: '0};
      end else begin
        win_cnt_reg <= win_cnt_reg + WINDOW_LOG2'(1);
        if (window_end) begin
          feedback_data_reg   <= fb_word;
          feedback_update_reg <= 1'b1;
          acc_reg             <= '0;
          cnt_reg             <= '{default: '0};
        end else begin
          acc_reg <= acc_sum;
          cnt_reg <= cnt_next;
        end
      end
    end
  end

  assign bus.feedback_data   = feedback_data_reg;
  assign bus.feedback_update = feedback_update_reg;
  assign bus.last_bd_delay   = last_bd_delay;

endmodule
